// File: rtl/axi_wr_slave_buffered_if.sv
// axi_wr_slave_buffered_if: AXI3 write channels plus engine-side command, data and response handshakes
interface axi_wr_slave_buffered_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [LEN_WIDTH-1:0]    awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ID_WIDTH-1:0]     cmd_id;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic [2:0]              cmd_size;
    logic [1:0]              cmd_burst;
    logic                    wd_valid;
    logic                    wd_ready;
    logic [DATA_WIDTH-1:0]   wd_data;
    logic [DATA_WIDTH/8-1:0] wd_strb;
    logic                    wd_last;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_resp;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  cmd_ready,
        output wd_valid, wd_data, wd_strb, wd_last,
        input  wd_ready,
        input  rsp_valid, rsp_resp,
        output rsp_ready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output cmd_ready,
        input  wd_valid, wd_data, wd_strb, wd_last,
        output wd_ready,
        output rsp_valid, rsp_resp,
        input  rsp_ready
    );
endinterface

// File: rtl/axi_wr_slave_buffered.sv
// axi_wr_slave_buffered: AXI3 write slave front end with W beat FIFO; AXI_WR_LEN_CHECK_EN enables burst length checking
module axi_wr_slave_buffered #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int WBUF_DEPTH = 8
) (
    input logic clk,
    input logic rst_n,
    axi_wr_slave_buffered_if.slave bus
);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int FW = DATA_WIDTH + DATA_WIDTH / 8 + 1;

    typedef enum logic [1:0] {IDLE, DATA, WAIT_RSP, RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   cmd_id_q, cmd_id_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_WIDTH-1:0]  cmd_len_q, cmd_len_d;
    logic [2:0]            cmd_size_q, cmd_size_d;
    logic [1:0]            cmd_burst_q, cmd_burst_d;
    logic                  cmd_pend_q, cmd_pend_d;
    logic [LEN_WIDTH:0]    beat_q, beat_d;
    logic                  err_q, err_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [FW-1:0]         fifo_mem [WBUF_DEPTH];
    logic                  full, empty, push, pop, beat_end, beat_err;

    assign full  = cnt_q == (PW + 1)'(WBUF_DEPTH);
    assign empty = cnt_q == '0;
    assign push  = bus.wvalid & bus.wready;
    assign pop   = !empty & bus.wd_ready & (state_q != IDLE);

`ifdef AXI_WR_LEN_CHECK_EN
    // A burst ends on wlast or on the awlen+1 beat, whichever comes first; disagreement is an error
    assign beat_end = bus.wlast | (beat_q == {1'b0, cmd_len_q});
    assign beat_err = bus.wlast != (beat_q == {1'b0, cmd_len_q});
`else
    assign beat_end = bus.wlast;
    assign beat_err = 1'b0;
    logic beat_unused;
    assign beat_unused = ^{beat_q, err_q};
`endif

    logic wid_unused;
    assign wid_unused = ^bus.wid;

    assign bus.awready   = state_q == IDLE;
    assign bus.wready    = (state_q == DATA) & !full;
    assign bus.cmd_valid = cmd_pend_q;
    assign bus.cmd_id    = cmd_id_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_len   = cmd_len_q;
    assign bus.cmd_size  = cmd_size_q;
    assign bus.cmd_burst = cmd_burst_q;
    assign bus.wd_valid  = !empty;
    assign {bus.wd_data, bus.wd_strb, bus.wd_last} = fifo_mem[rd_ptr_q];
    assign bus.rsp_ready = (state_q == WAIT_RSP) & empty & !cmd_pend_q;
    assign bus.bvalid    = state_q == RESP;
    assign bus.bid       = bid_q;
    assign bus.bresp     = bresp_q;

    // Next-state logic for the burst FSM, captured command, beat counter and FIFO pointers
    always_comb begin
        state_d     = state_q;
        cmd_id_d    = cmd_id_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_size_d  = cmd_size_q;
        cmd_burst_d = cmd_burst_q;
        cmd_pend_d  = cmd_pend_q & !bus.cmd_ready;
        beat_d      = beat_q;
        err_d       = err_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        cnt_d       = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        if (bus.awvalid && state_q == IDLE) begin
            cmd_id_d    = bus.awid;
            cmd_addr_d  = bus.awaddr;
            cmd_len_d   = bus.awlen;
            cmd_size_d  = bus.awsize;
            cmd_burst_d = bus.awburst;
            cmd_pend_d  = 1'b1;
            beat_d      = '0;
            err_d       = 1'b0;
            state_d     = DATA;
        end
        if (push) begin
            beat_d  = beat_q + 1'b1;
            err_d   = err_q | beat_err;
            state_d = beat_end ? WAIT_RSP : state_q;
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            bid_d   = cmd_id_q;
            bresp_d = err_q ? 2'b10 : bus.rsp_resp;
            state_d = RESP;
        end
        if (bus.bvalid && bus.bready) state_d = IDLE;
    end

    // Control and capture registers; reset drops any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_id_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_size_q  <= '0;
            cmd_burst_q <= '0;
            cmd_pend_q  <= 1'b0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_id_q    <= cmd_id_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_size_q  <= cmd_size_d;
            cmd_burst_q <= cmd_burst_d;
            cmd_pend_q  <= cmd_pend_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // FIFO storage; the stored last flag marks the beat that ended the burst
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.wdata, bus.wstrb, beat_end};
    end
endmodule

// File: tb/tb_axi_wr_slave_buffered.sv
// tb_axi_wr_slave_buffered: directed self-checking bench for axi_wr_slave_buffered
module tb_axi_wr_slave_buffered;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef AXI_WR_LEN_CHECK_EN
    localparam logic [1:0] LEN_ERR_RESP = 2'b10;
`else
    localparam logic [1:0] LEN_ERR_RESP = 2'b00;
`endif

    axi_wr_slave_buffered_if bus();

    axi_wr_slave_buffered dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string p);
        check({p, "_awready"}, bus.awready, 1);
        check({p, "_wready"}, bus.wready, 0);
        check({p, "_bvalid"}, bus.bvalid, 0);
        check({p, "_cmd_valid"}, bus.cmd_valid, 0);
        check({p, "_wd_valid"}, bus.wd_valid, 0);
        check({p, "_rsp_ready"}, bus.rsp_ready, 0);
        check({p, "_bid"}, bus.bid, 0);
        check({p, "_bresp"}, bus.bresp, 0);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        while (!bus.awready && n < 200) begin cyc(); n++; end
        if (!bus.awready) check("aw_timeout", bus.awready, 1);
        cyc();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic last);
        int n = 0;
        bus.wdata = d; bus.wstrb = 4'hF; bus.wlast = last; bus.wid = 4'h0; bus.wvalid = 1'b1;
        while (!bus.wready && n < 200) begin cyc(); n++; end
        if (!bus.wready) check("w_timeout", bus.wready, 1);
        exp_q.push_back(d);
        cyc();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic take_cmd();
        int n = 0;
        while (!bus.cmd_valid && n < 200) begin cyc(); n++; end
        if (!bus.cmd_valid) check("cmd_timeout", bus.cmd_valid, 1);
        bus.cmd_ready = 1'b1;
        cyc();
        bus.cmd_ready = 1'b0;
    endtask

    task automatic pop_beats(input int cnt);
        int got = 0;
        int t = 0;
        bus.wd_ready = 1'b1;
        while (got < cnt && t < 400) begin
            if (bus.wd_valid) begin
                if (exp_q.size() == 0) check("wd_extra", bus.wd_data, 0);
                else check("wd_data", bus.wd_data, exp_q.pop_front());
                check("wd_last", bus.wd_last, got == cnt - 1);
                got++;
            end
            cyc();
            t++;
        end
        bus.wd_ready = 1'b0;
        if (got != cnt) check("pop_timeout", got, cnt);
    endtask

    task automatic respond(input logic [1:0] r);
        int n = 0;
        bus.rsp_resp = r; bus.rsp_valid = 1'b1;
        while (!bus.rsp_ready && n < 200) begin cyc(); n++; end
        if (!bus.rsp_ready) check("rsp_timeout", bus.rsp_ready, 1);
        cyc();
        bus.rsp_valid = 1'b0;
    endtask

    task automatic get_b(input logic [3:0] id, input logic [1:0] r);
        int n = 0;
        bus.bready = 1'b1;
        while (!bus.bvalid && n < 200) begin cyc(); n++; end
        check("b_valid", bus.bvalid, 1);
        check("b_id", bus.bid, id);
        check("b_resp", bus.bresp, r);
        cyc();
        bus.bready = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input int pop_delay);
        fork
            begin
                send_aw(id, addr, len);
                for (int i = 0; i <= int'(len); i++) send_w({id, 4'h0, addr[15:0], 8'(i)}, i == int'(len));
            end
            begin
                take_cmd();
                repeat (pop_delay) cyc();
                pop_beats(int'(len) + 1);
                respond(2'b00);
            end
        join
        get_b(id, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.cmd_ready = 1'b0; bus.wd_ready = 1'b0;
        bus.rsp_valid = 1'b0; bus.rsp_resp = '0;
        repeat (3) cyc();
        check_reset("rst");
        rst_n = 1'b1;
        cyc();

        // single beat burst with explicit latency checks
        bus.awid = 4'd3; bus.awaddr = 32'h100; bus.awlen = 4'd0;
        bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        check("t1_awready", bus.awready, 1);
        cyc();
        bus.awvalid = 1'b0;
        check("t1_cmd_valid", bus.cmd_valid, 1);
        check("t1_cmd_id", bus.cmd_id, 3);
        check("t1_cmd_addr", bus.cmd_addr, 32'h100);
        check("t1_cmd_burst", bus.cmd_burst, 2'b01);
        check("t1_awready_busy", bus.awready, 0);
        bus.cmd_ready = 1'b1;
        cyc();
        bus.cmd_ready = 1'b0;
        check("t1_cmd_clr", bus.cmd_valid, 0);
        send_w(32'hDEADBEEF, 1'b1);
        check("t1_wd_valid", bus.wd_valid, 1);
        check("t1_wd_data", bus.wd_data, 32'hDEADBEEF);
        pop_beats(1);
        respond(2'b00);
        check("t1_bvalid", bus.bvalid, 1);
        get_b(4'd3, 2'b00);
        check("t1_awready_back", bus.awready, 1);

        // 16-beat burst fills the 8-entry FIFO before draining
        send_aw(4'd5, 32'h200, 4'd15);
        take_cmd();
        for (int i = 0; i < 8; i++) send_w(32'h2000 + i, 1'b0);
        check("t2_wready_full", bus.wready, 0);
        check("t2_wd_valid", bus.wd_valid, 1);
        fork
            for (int i = 8; i < 16; i++) send_w(32'h2000 + i, i == 15);
            pop_beats(16);
        join
        respond(2'b00);
        get_b(4'd5, 2'b00);

        // SLVERR held while bready stays low
        send_aw(4'd6, 32'h300, 4'd0);
        take_cmd();
        send_w(32'h3333, 1'b1);
        pop_beats(1);
        respond(2'b10);
        for (int i = 0; i < 5; i++) begin
            check("t3_bvalid", bus.bvalid, 1);
            check("t3_bresp", bus.bresp, 2'b10);
            check("t3_bid", bus.bid, 6);
            check("t3_awready", bus.awready, 0);
            cyc();
        end
        get_b(4'd6, 2'b10);
        check("t3_awready_back", bus.awready, 1);

        // reset in the middle of an 8-beat burst
        send_aw(4'd7, 32'h400, 4'd7);
        take_cmd();
        for (int i = 0; i < 3; i++) send_w(32'h4000 + i, 1'b0);
        check("t4_wd_valid_pre", bus.wd_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset("t4");
        cyc();
        rst_n = 1'b1;
        exp_q.delete();
        cyc();
        run_burst(4'd8, 32'h500, 4'd1, 0);

        // early wlast on beat 2 of a 4-beat burst
        send_aw(4'd9, 32'h600, 4'd3);
        take_cmd();
        send_w(32'h6000, 1'b0);
        send_w(32'h6001, 1'b1);
        check("t5_wready_end", bus.wready, 0);
        pop_beats(2);
        respond(2'b00);
        get_b(4'd9, LEN_ERR_RESP);

        // back-to-back full bursts with push and pop overlapping around full
        run_burst(4'd10, 32'h700, 4'd15, 10);
        run_burst(4'd11, 32'h800, 4'd15, 9);
        check("t6_sb_empty", exp_q.size(), 0);
        check("t6_wd_valid", bus.wd_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
